// File: rtl/fix_ari_pkg.sv
// Shared widths, types and sign-magnitude helpers
// for the fixed-point MAC datapath.
package fix_ari_pkg;

  localparam int DATA      = 16;
  localparam int INTE      = 7;
  localparam int POIN      = 8;
  localparam int ACC_GUARD = 8;

  localparam int MW = DATA - 1;
  localparam int PW = 2 * MW;
  localparam int TW = PW + 1;
  localparam int AW = TW + ACC_GUARD;

  typedef logic [DATA-1:0]      word_t;
  typedef logic [MW-1:0]        mag_t;
  typedef logic [PW-1:0]        prod_t;
  typedef logic signed [TW-1:0] tc_t;
  typedef logic signed [AW-1:0] acc_t;

  typedef struct packed {
    logic  ovf;
    word_t data;
  } res_t;

  localparam logic signed [AW:0] SMAX =
    (AW+1)'((1 << MW) - 1);
  localparam logic signed [AW:0] RND =
    (AW+1)'(1 << (POIN - 1));

  function automatic tc_t sm2tc(
    input logic  sgn,
    input prod_t mag
  );
    tc_t m;
    m = tc_t'({1'b0, mag});
    return sgn ? -m : m;
  endfunction

  // One extra bit keeps the rounding add from wrapping.
  function automatic res_t tc2sm_sat(
    input acc_t v
  );
    logic signed [AW:0] r;
    logic signed [AW:0] s;
    logic signed [AW:0] m;
    res_t o;
    r = {v[AW-1], v} + RND;
    s = r >>> POIN;
    m = -s;
    o.ovf = 1'b0;
    if (s > SMAX) begin
      o.data = {1'b0, {MW{1'b1}}};
      o.ovf  = 1'b1;
    end else if (s < -SMAX) begin
      o.data = {1'b1, {MW{1'b1}}};
      o.ovf  = 1'b1;
    end else if (s < 0) begin
      o.data = {1'b1, m[MW-1:0]};
    end else begin
      o.data = {1'b0, s[MW-1:0]};
    end
    return o;
  endfunction

endpackage

// File: rtl/fix_ari_mac_if.sv
// Operand/result handshake bundle
// for the fixed-point MAC.
interface fix_ari_mac_if;

  logic                in_valid;
  logic                in_ready;
  fix_ari_pkg::word_t  data_in1;
  fix_ari_pkg::word_t  data_in2;
  logic                acc_en;
  logic                acc_last;
  logic                out_valid;
  logic                out_ready;
  fix_ari_pkg::word_t  data_out;
  logic                ovf;

  modport master (
    output in_valid, data_in1, data_in2,
    output acc_en, acc_last, out_ready,
    input  in_ready, out_valid, data_out, ovf
  );

  modport slave (
    input  in_valid, data_in1, data_in2,
    input  acc_en, acc_last, out_ready,
    output in_ready, out_valid, data_out, ovf
  );

endinterface

// File: rtl/fix_ari_mul_core.sv
// Two-stage magnitude multiplier: register
// operands and sign, then register the product.
module fix_ari_mul_core
  import fix_ari_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  input  logic       vld_i,
  input  word_t      a_i,
  input  word_t      b_i,
  input  logic [1:0] ctl_i,
  output logic       vld_o,
  output logic       sgn_o,
  output logic [1:0] ctl_o,
  output prod_t      pm_o
);

  logic       s1_vld_q;
  logic       s1_sgn_q;
  logic [1:0] s1_ctl_q;
  mag_t       ma_q;
  mag_t       mb_q;
  logic       s1_sgn_d;

  logic       s2_vld_q;
  logic       s2_sgn_q;
  logic [1:0] s2_ctl_q;
  prod_t      pm_q;

  // A zero magnitude on either side forces a positive product.
  always_comb begin
    s1_sgn_d = (a_i[DATA-1] ^ b_i[DATA-1])
             & (|a_i[MW-1:0]) & (|b_i[MW-1:0]);
  end

  // S1: capture magnitudes, sign and beat control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sgn_q <= 1'b0;
      s1_ctl_q <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
    end else if (adv_i) begin
      s1_vld_q <= vld_i;
      s1_sgn_q <= s1_sgn_d;
      s1_ctl_q <= ctl_i;
      ma_q     <= a_i[MW-1:0];
      mb_q     <= b_i[MW-1:0];
    end
  end

  // S2: full-width unsigned magnitude product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_sgn_q <= 1'b0;
      s2_ctl_q <= '0;
      pm_q     <= '0;
    end else if (adv_i) begin
      s2_vld_q <= s1_vld_q;
      s2_sgn_q <= s1_sgn_q;
      s2_ctl_q <= s1_ctl_q;
      pm_q     <= PW'(ma_q) * PW'(mb_q);
    end
  end

  assign vld_o = s2_vld_q;
  assign sgn_o = s2_sgn_q;
  assign ctl_o = s2_ctl_q;
  assign pm_o  = pm_q;

endmodule

// File: rtl/fix_ari_mac.sv
// Pipelined sign-magnitude multiply /
// multiply-accumulate with round and saturate.
module fix_ari_mac
  import fix_ari_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  fix_ari_mac_if.slave bus
);

  logic       adv;
  logic       c_vld;
  logic       c_sgn;
  logic [1:0] c_ctl;
  prod_t      c_pm;

  logic       pv_q;
  logic [1:0] pctl_q;
  tc_t        p_q;

  acc_t       acc_q, acc_d;
  logic       act_q, act_d;
  logic       ov_q, ov_d;
  word_t      dat_q, dat_d;
  logic       ovf_q, ovf_d;

  acc_t       p_ext;
  acc_t       sum;
  res_t       res;

  assign adv          = !ov_q | bus.out_ready;
  assign bus.in_ready = adv;

  fix_ari_mul_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (adv),
    .vld_i (bus.in_valid),
    .a_i   (bus.data_in1),
    .b_i   (bus.data_in2),
    .ctl_i ({bus.acc_en, bus.acc_en & bus.acc_last}),
    .vld_o (c_vld),
    .sgn_o (c_sgn),
    .ctl_o (c_ctl),
    .pm_o  (c_pm)
  );

  // Signed product stage ahead of the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      pctl_q <= '0;
      p_q    <= '0;
    end else if (adv) begin
      pv_q   <= c_vld;
      pctl_q <= c_ctl;
      p_q    <= sm2tc(c_sgn, c_pm);
    end
  end

  // Accumulate or pass through, then round/saturate the result.
  always_comb begin
    acc_d = acc_q;
    act_d = act_q;
    ov_d  = ov_q;
    dat_d = dat_q;
    ovf_d = ovf_q;
    p_ext = acc_t'(p_q);
    sum   = act_q ? acc_q + p_ext : p_ext;
    res   = tc2sm_sat(pctl_q[1] ? sum : p_ext);
    if (adv) begin
      ov_d = 1'b0;
      if (pv_q) begin
        if (pctl_q[1]) begin
          acc_d = sum;
          act_d = !pctl_q[0];
        end
        if (!pctl_q[1] || pctl_q[0]) begin
          ov_d  = 1'b1;
          dat_d = res.data;
          ovf_d = res.ovf;
        end
      end
    end
  end

  // Accumulator and output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      act_q <= 1'b0;
      ov_q  <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      act_q <= act_d;
      ov_q  <= ov_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.data_out  = dat_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fix_ari_mac.sv
// Scoreboard bench for the fixed-point MAC
// with directed Q7.8 vectors.
module tb_fix_ari_mac;
  import fix_ari_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fix_ari_mac_if bus ();

  fix_ari_mac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   mon_n = 0;
  res_t sb[$];
  res_t mon_e;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want none",
                 bus.data_out);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("res%0d_data", mon_n),
            32'(bus.data_out), 32'(mon_e.data));
        chk($sformatf("res%0d_ovf", mon_n),
            32'(bus.ovf), 32'(mon_e.ovf));
        mon_n++;
      end
    end
  end

  task automatic beat(input word_t a, input word_t b,
                      input logic en, input logic last,
                      input logic exp, input word_t ed,
                      input logic eo);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.data_in1 = a;
    bus.data_in2 = b;
    bus.acc_en   = en;
    bus.acc_last = last;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      if (exp) sb.push_back('{ovf: eo, data: ed});
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  word_t va[8] = '{16'h8180, 16'h0000, 16'h8000, 16'h0001,
                   16'h8001, 16'h6400, 16'hE400, 16'h8180};
  word_t vb[8] = '{16'h0200, 16'h8100, 16'h8100, 16'h0080,
                   16'h0080, 16'h0200, 16'h0200, 16'h8200};
  word_t ve[8] = '{16'h8300, 16'h0000, 16'h0000, 16'h0001,
                   16'h0000, 16'h7FFF, 16'hFFFF, 16'h0300};
  logic  vo[8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b1, 1'b0};

  word_t sa[6] = '{16'h0100, 16'h0200, 16'h0300,
                   16'h8100, 16'h0080, 16'h0400};
  word_t sbv[6] = '{16'h0100, 16'h0100, 16'h0100,
                    16'h0100, 16'h0080, 16'h0100};
  word_t se[6] = '{16'h0100, 16'h0200, 16'h0300,
                   16'h8100, 16'h0040, 16'h0400};

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in1  = '0;
    bus.data_in2  = '0;
    bus.acc_en    = 1'b0;
    bus.acc_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    beat(16'h0180, 16'h0200, 0, 0, 1, 16'h0300, 0);
    chk("lat_n0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n3", 32'(bus.out_valid), 32'd1);
    drain("drain_lat");

    for (int i = 0; i < 8; i++)
      beat(va[i], vb[i], 0, 0, 1, ve[i], vo[i]);
    drain("drain_vec");

    for (int i = 0; i < 4; i++)
      beat(16'h0100, 16'h0100, 1, i == 3, i == 3,
           16'h0400, 0);
    for (int i = 0; i < 3; i++)
      beat(16'h0080, 16'h0200, 1, i == 2, i == 2,
           16'h0300, 0);
    drain("drain_acc");

    beat(16'h0100, 16'h0100, 1, 0, 0, 16'h0000, 0);
    beat(16'h0180, 16'h0200, 0, 0, 1, 16'h0300, 0);
    repeat (2) @(negedge clk);
    beat(16'h0100, 16'h0200, 1, 1, 1, 16'h0300, 0);
    beat(16'hE400, 16'h0200, 1, 1, 1, 16'hFFFF, 1);
    drain("drain_pass");

    fork
      begin
        for (int i = 0; i < 6; i++)
          beat(sa[i], sbv[i], 0, 0, 1, se[i], 0);
      end
      begin
        word_t h;
        h = '0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_in_ready", k),
              32'(bus.in_ready), 32'd0);
          if (k == 0) begin
            h = bus.data_out;
            chk("stall_head", 32'(h), 32'h0100);
          end else begin
            chk($sformatf("stall%0d_hold", k),
                32'(bus.data_out), 32'(h));
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    beat(16'h0100, 16'h0100, 1, 0, 0, 16'h0000, 0);
    beat(16'h0100, 16'h0100, 1, 0, 0, 16'h0000, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    beat(16'h0200, 16'h0100, 1, 1, 1, 16'h0200, 0);
    drain("drain_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
